// File: rtl/posit_seq_pkg.sv
// Shared types and default sizing for the posit dot-product sequencer.
// Holds the FSM state enum, default parameters and a width helper.
package posit_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        GAP
    } state_t;

    localparam int WIDTH_DEF  = 8;
    localparam int K_DEF      = 9;
    localparam int N_OUT_DEF  = 4;
    localparam int TO_CYC_DEF = 64;

    // $clog2 that never returns 0, for index ports of 1-deep ranges
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/posit_seq_rd_pipe.sv
// Two-stage alignment from memory read strobe to registered MAC operands.
// Ports: rd_i strobe, w/d_rdata_i read data (t+1), vld/win/din_o (t+2).
module posit_seq_rd_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn,
    input  logic             rd_i,
    input  logic [WIDTH-1:0] w_rdata_i,
    input  logic [WIDTH-1:0] d_rdata_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] win_o,
    output logic [WIDTH-1:0] din_o
);

    logic rd_q;

    // operands forced to 0 outside valid cycles
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            rd_q  <= 1'b0;
            vld_o <= 1'b0;
            win_o <= '0;
            din_o <= '0;
        end else begin
            rd_q  <= rd_i;
            vld_o <= rd_q;
            win_o <= rd_q ? w_rdata_i : '0;
            din_o <= rd_q ? d_rdata_i : '0;
        end
    end

endmodule

// File: rtl/posit_dot_seq.sv
// Sequencer feeding K-element operand bursts to the posit MAC, N_OUT per job,
// and forwarding each MAC result. Ports: start/busy/done job control, w_/d_
// memory reads, mac_* MAC link, res_* result port, err_o watchdog pulse.
// Build option POSIT_SEQ_TIMEOUT_EN adds a TO_CYC-cycle DRAIN watchdog.
module posit_dot_seq
    import posit_seq_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int K      = K_DEF,
    parameter int N_OUT  = N_OUT_DEF,
    parameter int WAW    = $clog2(K * N_OUT),
    parameter int DAW    = $clog2(K),
    parameter int IW     = clog2_min1(N_OUT),
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic             clk_i,
    input  logic             rstn,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             w_rd_o,
    output logic [WAW-1:0]   w_addr_o,
    input  logic [WIDTH-1:0] w_rdata_i,
    output logic             d_rd_o,
    output logic [DAW-1:0]   d_addr_o,
    input  logic [WIDTH-1:0] d_rdata_i,
    output logic             mac_vld_o,
    output logic [WIDTH-1:0] mac_win_o,
    output logic [WIDTH-1:0] mac_din_o,
    input  logic [WIDTH-1:0] mac_acc_i,
    input  logic             mac_vld_i,
    output logic             res_vld_o,
    output logic [IW-1:0]    res_idx_o,
    output logic [WIDTH-1:0] res_data_o,
    output logic             err_o
);

    localparam int KW = $clog2(K + 1);
    localparam int NW = $clog2(N_OUT + 1);

    state_t         state;
    state_t         state_n;
    logic [KW-1:0]  k;
    logic [NW-1:0]  idx;
    logic [WAW-1:0] base;
    logic           issue;
    logic           cap;
    logic           last;
    logic           to_hit;

    assign issue    = (state == ISSUE);
    assign w_rd_o   = issue;
    assign d_rd_o   = issue;
    assign w_addr_o = issue ? base + WAW'(k) : '0;
    assign d_addr_o = issue ? DAW'(k) : '0;
    assign last     = (idx == NW'(N_OUT - 1));

    // one capture per DRAIN; the FSM leaves DRAIN on the
    // registered result so start_i in the done cycle is ignored
    assign cap    = (state == DRAIN) && mac_vld_i && !res_vld_o;
    assign busy_o = (state != IDLE) && !done_o;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start_i) state_n = ISSUE;
            ISSUE: if (k == KW'(K - 1)) state_n = DRAIN;
            DRAIN: begin
                if (res_vld_o) state_n = last ? IDLE : GAP;
                else if (to_hit) state_n = IDLE;
            end
            GAP:   state_n = ISSUE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            k          <= '0;
            idx        <= '0;
            base       <= '0;
            res_vld_o  <= 1'b0;
            done_o     <= 1'b0;
            res_idx_o  <= '0;
            res_data_o <= '0;
        end else begin
            state     <= state_n;
            res_vld_o <= cap;
            done_o    <= cap && last;
            if (cap) begin
                res_data_o <= mac_acc_i;
                res_idx_o  <= IW'(idx);
            end
            if (state == IDLE && start_i) begin
                k    <= '0;
                idx  <= '0;
                base <= '0;
            end
            if (issue) begin
                k <= (k == KW'(K - 1)) ? '0 : k + KW'(1);
            end
            // row base steps by K instead of idx*K
            if (state == GAP) begin
                idx  <= idx + NW'(1);
                base <= base + WAW'(K);
            end
        end
    end

    posit_seq_rd_pipe #(
        .WIDTH (WIDTH)
    ) u_rd_pipe (
        .clk_i     (clk_i),
        .rstn      (rstn),
        .rd_i      (issue),
        .w_rdata_i (w_rdata_i),
        .d_rdata_i (d_rdata_i),
        .vld_o     (mac_vld_o),
        .win_o     (mac_win_o),
        .din_o     (mac_din_o)
    );

`ifdef POSIT_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    // counter is 0 on the first DRAIN cycle
    assign to_hit = (state == DRAIN) && !mac_vld_i && !res_vld_o
                  && (to_cnt == TW'(TO_CYC - 1));
    assign err_o  = err_q;

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q  <= to_hit;
            to_cnt <= (state == DRAIN) ? to_cnt + TW'(1) : '0;
        end
    end
`else
    // watchdog compiled out: DRAIN waits for the MAC forever
    localparam bit TO_OFF = (TO_CYC < 0);

    assign to_hit = TO_OFF;
    assign err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_posit_dot_seq.sv
// Directed bench for posit_dot_seq with memory and MAC models.
// Checks addressing, bursts, results, start/reset corner cases, watchdog.
module tb_posit_dot_seq;

    localparam int W   = 8;
    localparam int K   = 9;
    localparam int NO  = 4;
    localparam int LAT = 3;
    localparam int WAW = $clog2(K * NO);
    localparam int DAW = $clog2(K);
    localparam int IW  = (NO < 2) ? 1 : $clog2(NO);

    logic           clk_i   = 1'b0;
    logic           rstn    = 1'b0;
    logic           start_i = 1'b0;
    logic           busy_o;
    logic           done_o;
    logic           w_rd_o;
    logic [WAW-1:0] w_addr_o;
    logic [W-1:0]   w_rdata_i = '0;
    logic           d_rd_o;
    logic [DAW-1:0] d_addr_o;
    logic [W-1:0]   d_rdata_i = '0;
    logic           mac_vld_o;
    logic [W-1:0]   mac_win_o;
    logic [W-1:0]   mac_din_o;
    logic [W-1:0]   mac_acc_i;
    logic           mac_vld_i;
    logic           res_vld_o;
    logic [IW-1:0]  res_idx_o;
    logic [W-1:0]   res_data_o;
    logic           err_o;

    logic [W-1:0] wmem [2**WAW];
    logic [W-1:0] dmem [2**DAW];

    logic         hold = 1'b0;
    logic         spur = 1'b0;
    logic         mvld;
    logic [W-1:0] acc;
    int           mcnt;
    int           pend;
    int           nb;

    always #5 clk_i = ~clk_i;

    posit_dot_seq dut (
        .clk_i      (clk_i),
        .rstn       (rstn),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .w_rd_o     (w_rd_o),
        .w_addr_o   (w_addr_o),
        .w_rdata_i  (w_rdata_i),
        .d_rd_o     (d_rd_o),
        .d_addr_o   (d_addr_o),
        .d_rdata_i  (d_rdata_i),
        .mac_vld_o  (mac_vld_o),
        .mac_win_o  (mac_win_o),
        .mac_din_o  (mac_din_o),
        .mac_acc_i  (mac_acc_i),
        .mac_vld_i  (mac_vld_i),
        .res_vld_o  (res_vld_o),
        .res_idx_o  (res_idx_o),
        .res_data_o (res_data_o),
        .err_o      (err_o)
    );

    // synchronous memories, 0xEE on non-read cycles
    always @(posedge clk_i) begin
        w_rdata_i <= w_rd_o ? wmem[w_addr_o] : 8'hEE;
        d_rdata_i <= d_rd_o ? dmem[d_addr_o] : 8'hEE;
    end

    // MAC model: result 0x5C+n, LAT cycles after the K-th operand
    assign mac_vld_i = mvld | spur;
    assign mac_acc_i = acc;

    always @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            mcnt <= 0;
            pend <= 0;
            mvld <= 1'b0;
            acc  <= '0;
            nb   <= 0;
        end else begin
            mvld <= 1'b0;
            if (mac_vld_o) begin
                if (mcnt == K - 1) begin
                    mcnt <= 0;
                    if (!hold) pend <= LAT;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
            if (pend != 0) pend <= pend - 1;
            if (pend == 1) begin
                mvld <= 1'b1;
                acc  <= 8'(8'h5C + nb);
                nb   <= nb + 1;
            end else if (!busy_o) begin
                nb <= 0;
            end
        end
    end

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int rk, ridx, rcnt, run, vb, first_rd;
    int ndone  = 0;
    int nres   = 0;
    int n, sd, sr;
    bit bprev, lat_pend;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance to the next falling edge and run the stream checks
    task automatic tick();
        @(negedge clk_i);
        cyc++;
        if (!rstn) begin
            rk = 0; ridx = 0; rcnt = 0; run = 0; vb = 0;
            bprev = 0; lat_pend = 0;
            return;
        end
        if (busy_o && !bprev) begin
            rk = 0; ridx = 0; rcnt = 0; run = 0; vb = 0;
            lat_pend = 0;
        end
        chk("d_rd_eq_w_rd", d_rd_o, w_rd_o);
        if (w_rd_o) begin
            chk("w_addr", w_addr_o, ridx * K + rk);
            chk("d_addr", d_addr_o, rk);
            if (ridx == 0 && rk == 0) begin
                first_rd = cyc;
                lat_pend = 1;
            end
            rk++;
            if (rk == K) begin
                rk = 0;
                ridx++;
            end
        end
        if (mac_vld_o) begin
            if (lat_pend) begin
                chk("first_vld_lat", cyc - first_rd, 2);
                lat_pend = 0;
            end
            chk("mac_win", mac_win_o, wmem[(vb * K + run) % (K * NO)]);
            chk("mac_din", mac_din_o, dmem[run % K]);
            run++;
        end else begin
            if (run != 0) begin
                chk("burst_len", run, K);
                vb++;
                run = 0;
            end
            chk("win_idle", mac_win_o, 0);
            chk("din_idle", mac_din_o, 0);
        end
        if (res_vld_o) begin
            chk("res_idx", res_idx_o, rcnt);
            chk("res_data", res_data_o, 8'h5C + rcnt);
            chk("done_on_last", done_o, rcnt == NO - 1);
            rcnt++;
            nres++;
        end else begin
            chk("done_alone", done_o, 0);
        end
        if (done_o) begin
            ndone++;
            chk("busy_at_done", busy_o, 0);
        end
        bprev = busy_o;
    endtask

    task automatic run_to_done(input string tag);
        n = 0;
        while (!done_o && n < 400) begin
            tick();
            n++;
        end
        chk(tag, done_o, 1);
    endtask

    initial begin
        for (int i = 0; i < 2**WAW; i++)
            wmem[i] = (i < K) ? 8'h40 : 8'(16 + i * 5);
        for (int j = 0; j < 2**DAW; j++)
            dmem[j] = 8'(8'h40 + j);

        repeat (3) tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_w_rd", w_rd_o, 0);
        chk("rst_w_addr", w_addr_o, 0);
        chk("rst_d_addr", d_addr_o, 0);
        chk("rst_mac_vld", mac_vld_o, 0);
        chk("rst_mac_win", mac_win_o, 0);
        chk("rst_res_vld", res_vld_o, 0);
        chk("rst_res_data", res_data_o, 0);
        chk("rst_res_idx", res_idx_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        rstn = 1'b1;
        tick();
        tick();

        // job 1 with start and spurious MAC valid during ISSUE
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("busy_after_start", busy_o, 1);
        repeat (3) tick();
        chk("in_issue", w_rd_o, 1);
        start_i = 1'b1;
        spur    = 1'b1;
        tick();
        start_i = 1'b0;
        spur    = 1'b0;
        chk("spur_issue_nores", res_vld_o, 0);
        run_to_done("job1_done");
        chk("job1_results", rcnt, NO);
        chk("job1_bursts", vb, NO);
        chk("job1_ndone", ndone, 1);

        // start in done cycle ignored, next cycle accepted
        start_i = 1'b1;
        tick();
        chk("start_in_done_ignored", busy_o, 0);
        tick();
        start_i = 1'b0;
        chk("start_after_done", busy_o, 1);

        // job 2: reset in DRAIN of idx 2
        n = 0;
        while (rcnt < 2 && n < 400) begin tick(); n++; end
        while (!w_rd_o && n < 400) begin tick(); n++; end
        while (w_rd_o && n < 400) begin tick(); n++; end
        chk("reached_drain2", n < 400, 1);
        chk("drain2_rows_read", ridx, 3);
        sd = ndone;
        sr = nres;
        #1 rstn = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_w_rd", w_rd_o, 0);
        chk("arst_mac_vld", mac_vld_o, 0);
        chk("arst_mac_din", mac_din_o, 0);
        chk("arst_res_vld", res_vld_o, 0);
        chk("arst_done", done_o, 0);
        tick();
        tick();
        rstn = 1'b1;
        repeat (20) tick();
        chk("no_done_after_rst", ndone, sd);
        chk("no_res_after_rst", nres, sr);
        chk("idle_after_rst", busy_o, 0);

        // job 3: fresh restart from idx 0
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("restart_busy", busy_o, 1);
        run_to_done("job3_done");
        chk("job3_results", rcnt, NO);
        chk("job3_ndone", ndone, sd + 1);
        tick();
        chk("res_data_hold", res_data_o, 8'h5F);
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("spur_idle_nores", res_vld_o, 0);
        chk("spur_idle_busy", busy_o, 0);

        // job 4: MAC withholds its result
        hold    = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (w_rd_o && n < 50) begin tick(); n++; end
`ifdef POSIT_SEQ_TIMEOUT_EN
        for (int i = 1; i < 64; i++) begin
            tick();
            chk("err_early", err_o, 0);
        end
        chk("busy_pre_timeout", busy_o, 1);
        tick();
        chk("err_pulse", err_o, 1);
        chk("busy_after_timeout", busy_o, 0);
        tick();
        chk("err_one_cycle", err_o, 0);
`else
        for (int i = 0; i < 80; i++) begin
            tick();
            chk("err_tied_low", err_o, 0);
        end
        chk("busy_waits", busy_o, 1);
`endif
        chk("no_done_timeout", ndone, sd + 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        hold = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
